vliw_fetch_sequencer: RTL and testbench



---
 rtl/vliw_pkg.sv | 21 ++
 rtl/vliw_loop_counter.sv | 31 +++
 rtl/vliw_fetch_sequencer.sv | 143 ++++++++++++++
 tb/tb_vliw_fetch_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vliw_pkg.sv
// Shared encodings for the VLIW fetch sequencer: opcodes, FSM states and
// the position of the opcode field inside an instruction word.
package vliw_pkg;

  // The opcode occupies the top OPC_W bits of every instruction word.
  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_NOP    = 4'h0;
  localparam logic [OPC_W-1:0] OP_EXEC   = 4'h1;
  localparam logic [OPC_W-1:0] OP_JMP    = 4'h2;
  localparam logic [OPC_W-1:0] OP_LOOP   = 4'h3;
  localparam logic [OPC_W-1:0] OP_SETCNT = 4'h4;
  localparam logic [OPC_W-1:0] OP_HALT   = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/vliw_loop_counter.sv
// Hardware loop counter: parallel load, decrement that saturates at zero,
// and a zero flag used by the LOOP opcode to decide whether to branch.
module vliw_loop_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  // Load has priority over decrement; a decrement at zero leaves the count at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/vliw_fetch_sequencer.sv
// Fetch/sequencing stage around an enable-less program counter. Holding and
// parking the PC is done by jumping to the current (or start) address.
module vliw_fetch_sequencer
  import vliw_pkg::*;
#(
  parameter int PC_W       = 6,
  parameter int INSTR_W    = 32,
  parameter int CNT_W      = 16,
  parameter int START_ADDR = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [PC_W-1:0]          program_counter,
  output logic [PC_W-1:0]          imem_addr,
  input  logic [INSTR_W-1:0]       imem_data,
  input  logic                     issue_stall,
  output logic                     jmp_en,
  output logic [PC_W-1:0]          jmp_target,
  output logic                     bundle_valid,
  output logic [INSTR_W-OPC_W-1:0] bundle_data,
  output logic [CNT_W-1:0]         loop_cnt,
  output logic                     busy,
  output logic                     done,
  output logic                     illegal_op
);

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  state_e                     state_q;
  logic                       bundle_valid_q;
  logic [INSTR_W-OPC_W-1:0]   bundle_data_q;
  logic                       done_q;
  logic                       illegal_q;

  logic [OPC_W-1:0]           opcode;
  logic                       cnt_load_d;
  logic                       cnt_dec_d;
  logic                       cnt_zero;
  logic                       issue_d;
  logic                       halt_d;
  logic                       illegal_d;

  assign imem_addr = program_counter;
  assign opcode    = imem_data[INSTR_W-1 -: OPC_W];

  // Decode: steer the PC through jmp_en/jmp_target and raise side-effect strobes.
  always_comb begin
    jmp_en     = 1'b1;
    jmp_target = program_counter;
    cnt_load_d = 1'b0;
    cnt_dec_d  = 1'b0;
    issue_d    = 1'b0;
    halt_d     = 1'b0;
    illegal_d  = 1'b0;
    case (state_q)
      S_IDLE: jmp_target = START_PC;
      S_RUN: begin
        if (!issue_stall) begin
          jmp_en = 1'b0;
          case (opcode)
            OP_NOP:    ;
            OP_EXEC:   issue_d = 1'b1;
            OP_JMP: begin
              jmp_en     = 1'b1;
              jmp_target = imem_data[PC_W-1:0];
            end
            OP_LOOP: begin
              if (!cnt_zero) begin
                jmp_en     = 1'b1;
                jmp_target = imem_data[PC_W-1:0];
                cnt_dec_d  = 1'b1;
              end
            end
            OP_SETCNT: cnt_load_d = 1'b1;
            OP_HALT: begin
              jmp_en = 1'b1;
              halt_d = 1'b1;
            end
            default:   illegal_d = 1'b1;
          endcase
        end
      end
      S_DONE: begin
        if (start) jmp_target = START_PC;
      end
      default: jmp_target = START_PC;
    endcase
  end

  // FSM with registered bundle, done and sticky illegal-opcode outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      bundle_valid_q <= 1'b0;
      bundle_data_q  <= '0;
      done_q         <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      bundle_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) state_q <= S_RUN;
        end
        S_RUN: begin
          bundle_valid_q <= issue_d;
          if (issue_d) bundle_data_q <= imem_data[INSTR_W-OPC_W-1:0];
          if (illegal_d) illegal_q <= 1'b1;
          if (halt_d) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          if (start) begin
            state_q <= S_RUN;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  vliw_loop_counter #(
    .CNT_W(CNT_W)
  ) u_loop_counter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load_d),
    .load_val_i (imem_data[CNT_W-1:0]),
    .dec_i      (cnt_dec_d),
    .cnt_o      (loop_cnt),
    .zero_o     (cnt_zero)
  );

  assign bundle_valid = bundle_valid_q;
  assign bundle_data  = bundle_data_q;
  assign busy         = (state_q == S_RUN);
  assign done         = done_q;
  assign illegal_op   = illegal_q;

endmodule

// File: tb/tb_vliw_fetch_sequencer.sv
// Bench for vliw_fetch_sequencer: a stand-in program counter, a small
// program memory, an instruction-level model checked every cycle, and
// directed programs with hand-computed expectations.
module tb_vliw_fetch_sequencer;

  localparam int PC_W    = 6;
  localparam int INSTR_W = 32;
  localparam int CNT_W   = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               issue_stall;
  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               jmp_en;
  logic [PC_W-1:0]    jmp_target;
  logic               bundle_valid;
  logic [27:0]        bundle_data;
  logic [CNT_W-1:0]   loop_cnt;
  logic               busy;
  logic               done;
  logic               illegal_op;

  logic [31:0] imem [64];

  int n_checks = 0;
  int n_pass   = 0;

  logic [27:0] log_q[$];

  always #5 clk = ~clk;

  assign imem_data = imem[imem_addr];

  // Stand-in program_counter: load on jump, otherwise increment (wraps).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_q <= '0;
    else if (jmp_en) pc_q <= jmp_target;
    else pc_q <= pc_q + 1'b1;
  end

  vliw_fetch_sequencer #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W), .START_ADDR(0)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .program_counter(pc_q),
    .imem_addr(imem_addr), .imem_data(imem_data), .issue_stall(issue_stall),
    .jmp_en(jmp_en), .jmp_target(jmp_target), .bundle_valid(bundle_valid),
    .bundle_data(bundle_data), .loop_cnt(loop_cnt), .busy(busy), .done(done),
    .illegal_op(illegal_op)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] ins(input logic [3:0] op, input logic [27:0] f);
    return {op, f};
  endfunction

  // Instruction-level model: mode 0 idle, 1 running, 2 finished.
  int          m_mode = 0;
  logic [5:0]  m_pc   = '0;
  logic [15:0] m_cnt  = '0;
  logic        m_ill  = 1'b0;
  logic        m_bv   = 1'b0;
  logic        m_done = 1'b0;
  logic [27:0] m_bd   = '0;

  always @(negedge clk) begin : compare
    logic [31:0] w;
    logic [3:0]  op;
    logic [5:0]  nxt;
    if (!rst) begin
      m_mode = 0; m_pc = '0; m_cnt = '0; m_ill = 0; m_bv = 0; m_done = 0; m_bd = '0;
      check("rst_jmp_en", jmp_en, 1);
      check("rst_jmp_target", jmp_target, 0);
      check("rst_bundle_valid", bundle_valid, 0);
      check("rst_bundle_data", bundle_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_loop_cnt", loop_cnt, 0);
      check("rst_illegal", illegal_op, 0);
    end else begin
      check("pc", pc_q, m_pc);
      check("imem_addr", imem_addr, pc_q);
      check("busy", busy, (m_mode == 1));
      check("done", done, m_done);
      check("bundle_valid", bundle_valid, m_bv);
      if (m_bv) check("bundle_data", bundle_data, m_bd);
      check("loop_cnt", loop_cnt, m_cnt);
      check("illegal_op", illegal_op, m_ill);
      if (bundle_valid) log_q.push_back(bundle_data);
      // Advance the model by one clock.
      w  = imem[m_pc];
      op = w[31:28];
      m_bv = 1'b0;
      case (m_mode)
        0: begin
          m_pc = 6'd0;
          if (start) m_mode = 1;
        end
        1: begin
          if (!issue_stall) begin
            nxt = m_pc + 6'd1;
            if (op == 4'd1) begin
              m_bv = 1'b1;
              m_bd = w[27:0];
            end else if (op == 4'd2) begin
              check("jmp_en_on_jmp", jmp_en, 1);
              check("jmp_target_on_jmp", jmp_target, w[5:0]);
              nxt = w[5:0];
            end else if (op == 4'd3) begin
              if (m_cnt != 0) begin
                m_cnt = m_cnt - 16'd1;
                nxt   = w[5:0];
              end
            end else if (op == 4'd4) begin
              m_cnt = w[15:0];
            end else if (op == 4'hF) begin
              nxt    = m_pc;
              m_mode = 2;
              m_done = 1'b1;
            end else if (op != 4'd0) begin
              m_ill = 1'b1;
            end
            m_pc = nxt;
          end
        end
        default: begin
          if (start) begin
            m_mode = 1;
            m_done = 1'b0;
            m_pc   = 6'd0;
          end
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    int k = 0;
    while (!done && k < max_cycles) begin
      tick();
      k++;
    end
    check("done_within_budget", done, 1);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; issue_stall = 1'b0;
    clear_imem();
    repeat (3) tick();
    check("lit_rst_jmp_en", jmp_en, 1);
    check("lit_rst_jmp_target", jmp_target, 0);
    check("lit_rst_busy", busy, 0);
    rst = 1'b1;
    tick(); tick();
    check("lit_idle_pc", pc_q, 0);

    // EXEC stream then jump over PC 4
    imem[0] = ins(4'h1, 28'h1);
    imem[1] = ins(4'h1, 28'h2);
    imem[2] = ins(4'h1, 28'h3);
    imem[3] = ins(4'h2, 28'd5);
    imem[4] = ins(4'h1, 28'h44);
    imem[5] = ins(4'hF, 28'h0);
    log_q.delete();
    pulse_start();
    check("lit_first_run_pc", pc_q, 0);
    check("lit_first_run_busy", busy, 1);
    wait_done(40);
    check("lit_exec_count", log_q.size(), 3);
    if (log_q.size() == 3) begin
      check("lit_exec0", log_q[0], 28'h1);
      check("lit_exec1", log_q[1], 28'h2);
      check("lit_exec2", log_q[2], 28'h3);
    end
    check("lit_halt_pc_a", pc_q, 5);
    $display("prog A: issued %0d bundles, halted at PC %0d", log_q.size(), pc_q);

    // Hardware loop
    clear_imem();
    imem[0] = ins(4'h4, 28'd2);
    imem[1] = ins(4'h1, 28'hA);
    imem[2] = ins(4'h3, 28'd1);
    imem[3] = ins(4'hF, 28'h0);
    log_q.delete();
    pulse_start();
    check("lit_restart_pc", pc_q, 0);
    wait_done(60);
    check("lit_loop_count", log_q.size(), 3);
    foreach (log_q[i]) check("lit_loop_payload", log_q[i], 28'hA);
    check("lit_loop_cnt_end", loop_cnt, 0);
    tick(); tick();
    check("lit_frozen_pc", pc_q, 3);
    check("lit_frozen_done", done, 1);
    $display("prog B: issued %0d bundles, loop_cnt %0d, PC %0d", log_q.size(), loop_cnt, pc_q);
    pulse_start();
    check("lit_again_pc", pc_q, 0);
    check("lit_again_done", done, 0);
    wait_done(60);

    // Issue stall on an EXEC
    clear_imem();
    imem[1] = ins(4'h1, 28'h55);
    imem[2] = ins(4'hF, 28'h0);
    log_q.delete();
    pulse_start();
    tick();
    check("lit_stall_at_pc1", pc_q, 1);
    issue_stall = 1'b1;
    tick();
    check("lit_stall1_pc", pc_q, 1);
    check("lit_stall1_bv", bundle_valid, 0);
    tick();
    check("lit_stall2_pc", pc_q, 1);
    check("lit_stall2_bv", bundle_valid, 0);
    issue_stall = 1'b0;
    tick();
    check("lit_unstall_bv", bundle_valid, 1);
    check("lit_unstall_bd", bundle_data, 28'h55);
    wait_done(20);
    check("lit_stall_issue_once", log_q.size(), 1);
    $display("prog C: issued %0d bundles after stall", log_q.size());

    // Illegal opcode, then asynchronous reset mid-run
    clear_imem();
    imem[0] = 32'h7000_0000;
    imem[1] = ins(4'h1, 28'h66);
    imem[2] = ins(4'h4, 28'd7);
    pulse_start();
    check("lit_ill_before", illegal_op, 0);
    tick();
    check("lit_ill_set", illegal_op, 1);
    check("lit_ill_pc", pc_q, 1);
    tick(); tick();
    check("lit_setcnt7", loop_cnt, 7);
    #2 rst = 1'b0;
    #1;
    check("lit_async_busy", busy, 0);
    check("lit_async_ill", illegal_op, 0);
    check("lit_async_cnt", loop_cnt, 0);
    check("lit_async_jmp_en", jmp_en, 1);
    check("lit_async_target", jmp_target, 0);
    $display("prog D: illegal flagged, async reset returned to idle");
    @(posedge clk); #1;
    rst = 1'b1;
    tick();

    // Loop counter boundary at zero and PC wrap from 63 to 0
    clear_imem();
    imem[0]  = ins(4'h3, 28'd4);
    imem[1]  = ins(4'h4, 28'd2);
    imem[2]  = ins(4'h3, 28'd62);
    imem[4]  = ins(4'hF, 28'h0);
    imem[62] = ins(4'h1, 28'h62);
    imem[63] = ins(4'h1, 28'h63);
    log_q.delete();
    pulse_start();
    tick();
    check("lit_loop_zero_fall", pc_q, 1);
    check("lit_loop_zero_cnt", loop_cnt, 0);
    wait_done(40);
    check("lit_wrap_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("lit_wrap0", log_q[0], 28'h62);
      check("lit_wrap1", log_q[1], 28'h63);
    end
    check("lit_wrap_halt_pc", pc_q, 4);
    check("lit_wrap_cnt", loop_cnt, 0);
    $display("prog E: issued %0d bundles across wrap, halted at PC %0d", log_q.size(), pc_q);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
